// File: rtl/ahb_arbiter.sv
// Four-master AHB bus arbiter: round-robin grant with beat-limited tenure,
// locked-transfer hold and one-transfer handover of the address phase.
module ahb_arbiter #(
  parameter int DEFAULT_MASTER = 0,
  parameter int MAX_BEATS      = 8
) (
  input  logic       hclk,
  input  logic       hreset,
  input  logic [3:0] hbusreq,
  input  logic [3:0] hlock,
  input  logic [1:0] htrans,
  input  logic       hready,
  output logic [3:0] hgrant,
  output logic [1:0] hmaster,
  output logic       hmastlock
);
  localparam logic [1:0] DEF  = 2'(DEFAULT_MASTER);
  localparam logic [7:0] MAXB = 8'(MAX_BEATS);

  typedef enum logic [1:0] {IDLE, OWNED, LOCKED} state_t;

  state_t     state, state_n;
  logic [1:0] owner, owner_n, ptr, ptr_n, win, idx;
  logic [7:0] beats, beats_n;
  logic       found, others, arb, active, tenure_end;

  // Grant is decoded from the registered owner index, so it is one-hot by construction.
  assign hgrant     = 4'b0001 << owner;
  assign others     = |(hbusreq & ~hgrant);
  assign active     = (htrans == 2'b10) || (htrans == 2'b11);
  assign tenure_end = !hbusreq[owner] || (beats == MAXB && others);

  // Round-robin search starting just after the last granted master.
  always_comb begin
    win   = ptr;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && hbusreq[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state;
    owner_n = owner;
    ptr_n   = ptr;
    beats_n = beats;
    arb     = 1'b0;
    if (hready) begin
      case (state)
        IDLE:   arb = 1'b1;
        OWNED:  arb = tenure_end;
        LOCKED: if (!hlock[owner]) begin
                  state_n = OWNED;
                  arb     = tenure_end;
                end
        default: arb = 1'b1;
      endcase
      // Every arbitration point starts a fresh tenure, even if the same master wins again.
      if (arb) begin
        beats_n = '0;
        if (found) begin
          owner_n = win;
          ptr_n   = win;
          state_n = hlock[win] ? LOCKED : OWNED;
        end else begin
          owner_n = DEF;
          state_n = IDLE;
        end
      end else if (active && beats != MAXB) begin
        beats_n = beats + 8'd1;
      end
    end
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state     <= IDLE;
      owner     <= DEF;
      ptr       <= '0;
      beats     <= '0;
      hmaster   <= DEF;
      hmastlock <= 1'b0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      ptr   <= ptr_n;
      beats <= beats_n;
      // Address phase follows the grant one completed transfer later.
      if (hready) begin
        hmaster   <= owner;
        hmastlock <= (state == LOCKED) && hlock[owner];
      end
    end
  end
endmodule
